// File: rtl/prog_counter_gen2.sv
// prog_counter_gen2: parametrised programmable up/down counter with a clock
// prescaler, programmable terminal value and three terminal-count modes
// (wrap, saturate, one-shot).
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   ena          project select; low freezes all state and forces tc low
//   load         synchronous load of load_val (highest priority)
//   load_val     value loaded on load
//   cnt_en       enables the prescaler and therefore counting
//   up_dn        1 = count up, 0 = count down
//   mode         00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   limit        terminal value when counting up, reload value for down-wrap
//   prescale     prescaler divide minus one
//   drive_en     output enable for the bus copy
//   count        registered count
//   count_oe     {WIDTH{drive_en}}, combinational
//   at_term      count == limit (up) or count == 0 (down), combinational
//   tc           registered one-cycle terminal-count pulse
//   done         sticky one-shot completion flag
module prog_counter_gen2 #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  cnt_en,
  input  logic                  up_dn,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  drive_en,
  output logic [WIDTH-1:0]      count,
  output logic [WIDTH-1:0]      count_oe,
  output logic                  at_term,
  output logic                  tc,
  output logic                  done
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0]      ONE_CNT = 1;
  localparam logic [PRESCALE_W-1:0] ONE_PRE = 1;

  mode_t                 mode_e;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic [PRESCALE_W-1:0] pre_cnt_nxt;
  logic [WIDTH-1:0]      count_nxt;
  logic                  tc_nxt;
  logic                  done_nxt;
  logic                  tick;
  logic                  term_evt;

  assign mode_e   = mode_t'(mode);
  assign count_oe = {WIDTH{drive_en}};
  assign at_term  = up_dn ? (count == limit) : (count == '0);

  // The prescaler only compares for equality, so a prescale lowered below
  // pre_cnt lets pre_cnt run to all-ones and wrap before it matches again.
  assign tick     = cnt_en && (pre_cnt == prescale);
  assign term_evt = tick && at_term;

  // Next-state logic. tc defaults low so it can only ever be a single-cycle
  // pulse following a wrap or one-shot terminal event.
  always_comb begin
    count_nxt   = count;
    pre_cnt_nxt = pre_cnt;
    tc_nxt      = 1'b0;
    done_nxt    = done;
    if (ena) begin
      if (load) begin
        count_nxt   = load_val;
        pre_cnt_nxt = '0;
        done_nxt    = 1'b0;
      end else begin
        if (cnt_en) begin
          pre_cnt_nxt = tick ? '0 : (pre_cnt + ONE_PRE);
        end
        // Once a one-shot has completed, ticks are swallowed until reload.
        if (tick && !done) begin
          if (term_evt) begin
            case (mode_e)
              MODE_SAT: begin
                count_nxt = count;
              end
              MODE_ONESHOT: begin
                done_nxt = 1'b1;
                tc_nxt   = 1'b1;
              end
              default: begin
                count_nxt = up_dn ? '0 : limit;
                tc_nxt    = 1'b1;
              end
            endcase
          end else begin
            // Plain modulo step; an up count above limit wraps silently.
            count_nxt = up_dn ? (count + ONE_CNT) : (count - ONE_CNT);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      pre_cnt <= '0;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else begin
      count   <= count_nxt;
      pre_cnt <= pre_cnt_nxt;
      tc      <= tc_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: doc/prog_counter_gen2.md
Name: prog_counter_gen2

Overview:
Parametrised successor to the 8-bit programmable counter. It has a configurable width, up/down direction, a programmable terminal (limit) value and a clock prescaler. Three terminal-count modes are supported: wrap, saturate and one-shot. It sits behind the TT pin wrapper and drives the count onto dedicated outputs and a tri-stateable bus copy.

Parameters:
WIDTH, 8, counter, load value and limit width in bits (2..32)
PRESCALE_W, 4, prescaler divide-field width; step rate = 1 per (prescale+1) enabled clocks

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  project-select; low freezes all state
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded on load
cnt_en  input  1  count/prescaler enable
up_dn  input  1  1=count up, 0=count down
mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
limit  input  WIDTH  terminal value for up counting; reload value for down-wrap
prescale  input  PRESCALE_W  prescaler divide minus one
drive_en  input  1  output enable for bus copy
count  output  WIDTH  current count (registered)
count_oe  output  WIDTH  {WIDTH{drive_en}}, combinational
at_term  output  1  combinational: count==limit (up_dn=1) or count==0 (up_dn=0)
tc  output  1  registered one-cycle terminal-count pulse
done  output  1  sticky one-shot completion flag

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. Reset values: count=0, pre_cnt=0, tc=0, done=0.
- ena=0: count, pre_cnt and done hold; tc is forced to 0 on the next edge. All rules below apply only when ena=1.
- Priority per edge: load > tick > hold.
- load=1: count<=load_val, pre_cnt<=0, done<=0, tc<=0. Any coincident tick is discarded.
- Prescaler: with cnt_en=1, tick = (pre_cnt==prescale).
  - On tick: pre_cnt<=0. Otherwise pre_cnt<=pre_cnt+1.
  - cnt_en=0: pre_cnt holds, no tick.
  - prescale=0 gives a tick on every enabled clock.
- Terminal event = tick while at_term=1.
- Tick without a terminal event: count <= count+1 (up) or count-1 (down), modulo 2^WIDTH.
  - An up count loaded above limit climbs to all-ones, wraps to 0 with no tc, then proceeds normally.
  - Down counting never passes 0 without a terminal event.
- Terminal event per mode:
  - wrap (00/11): count <= 0 (up) or limit (down); tc<=1 for exactly one cycle.
  - saturate (01): count holds; tc stays 0. at_term remains high while held.
  - one-shot (10): count holds, done<=1, tc<=1 for one cycle. While done=1, all ticks are ignored (prescaler still runs) until load.
- tc is 0 on every cycle that is not immediately after a wrap/one-shot terminal event.
- up_dn, mode, limit and prescale may change at any time and take effect on the next edge.
  - Lowering limit below count while counting up takes the modulo path above.
  - Lowering prescale below pre_cnt makes the prescaler run to all-ones, wrap, then match.
- done is cleared only by load or reset. A mode change does not clear it.
- limit=0 when counting up: every tick is a terminal event (wrap mode pulses tc every tick, count stays 0).
- Reset asserted mid-count clears all state immediately, independent of clk. First possible tick is prescale+1 enabled clocks after rst_n deasserts.

Test Plan:
- WIDTH=8, mode=00, up, limit=5, prescale=0, cnt_en=1 from count=0 -> count 0,1,2,3,4,5,0,1…; tc high exactly one cycle after each 5→0 transition.
- Down, mode=00, limit=9, load_val=2, prescale=2 -> count changes every 3 clocks: 2,1,0,9,8; tc pulses once after 0→9.
- mode=01, up, limit=200, load 198 -> 199, 200, then holds at 200; at_term=1, tc never asserted.
- mode=10, down, load 3 -> 2,1,0 then holds; done=1 and one tc pulse; further cnt_en has no effect; load 7 clears done, and counting resumes 6,5.
- load and tick on the same edge (load_val=0x40) -> count=0x40, pre_cnt=0, no tc. ena=0 for 4 cycles mid-count -> count frozen, tc=0. rst_n pulsed low between clock edges -> count=0 immediately.
- drive_en toggle -> count_oe all-ones/all-zeros combinationally. Loading count=0xFF above limit=0x10 while counting up -> 0x00 with no tc, continues to 0x10, then tc.
